// File: rtl/block_map.sv
// rtl/block_map.sv - block-field map RAM with level loader, destroy RMW and hit/score events
module block_map #(
    parameter int ROW    = 48,
    parameter int COL    = 32,
    parameter int TYPE_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [6:0]        row,
    input  logic [6:0]        col,
    output logic [TYPE_W-1:0] block,
    input  logic              destroy,
    input  logic [6:0]        d_row,
    input  logic [6:0]        d_col,
    output logic              d_ready,
    input  logic              load_start,
    input  logic              ld_valid,
    input  logic [TYPE_W-1:0] ld_data,
    output logic              ld_ready,
    output logic [10:0]       blocks_left,
    output logic              hit_valid,
    output logic [TYPE_W-1:0] hit_type,
    output logic              hit_kill,
    output logic              level_clear,
    output logic              busy
);

    localparam int CELLS = ROW * COL;
    localparam int AW    = $clog2(CELLS);
    localparam logic [AW-1:0] LAST = AW'(CELLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HIT_RD,
        S_HIT_WR
    } state_t;

    // Types 1..(all-ones - 1) can be hit; 0 is empty and all-ones is indestructible.
    function automatic logic is_breakable(input logic [TYPE_W-1:0] t);
        return (t != '0) && (t != '1);
    endfunction

    // Armored types above the lowest armored level step down by one; everything else clears.
    function automatic logic [TYPE_W-1:0] after_hit(input logic [TYPE_W-1:0] t);
        return (t >= TYPE_W'(13)) ? t - TYPE_W'(1) : '0;
    endfunction

    function automatic logic in_field(input logic [6:0] r, input logic [6:0] c);
        return (32'(r) < ROW) && (32'(c) < COL);
    endfunction

    // Out-of-field coordinates are folded onto cell 0; callers mask the result.
    function automatic logic [AW-1:0] cell_addr(input logic [6:0] r, input logic [6:0] c);
        return in_field(r, c) ? AW'(32'(r) * COL + 32'(c)) : '0;
    endfunction

    logic [TYPE_W-1:0] mem [CELLS];

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [10:0]       bl_q, bl_d;
    logic [AW-1:0]     tgt_q, tgt_d;
    logic              tgt_ok_q, tgt_ok_d;
    logic              a_ok_q, a_ok_d;
    logic              hit_valid_q, hit_valid_d;
    logic [TYPE_W-1:0] hit_type_q, hit_type_d;
    logic              hit_kill_q, hit_kill_d;
    logic              level_clear_q, level_clear_d;
    logic              d_ready_q, d_ready_d;
    logic              ld_ready_q, ld_ready_d;
    logic              busy_q, busy_d;

    logic [TYPE_W-1:0] rd_a_q;
    logic [TYPE_W-1:0] rd_b_q;
    logic [AW-1:0]     a_addr;
    logic              we_b;
    logic [AW-1:0]     wa_b;
    logic [TYPE_W-1:0] wd_b;
    logic [TYPE_W-1:0] new_type;

    assign a_addr   = cell_addr(row, col);
    assign new_type = after_hit(rd_b_q);

    // Next-state, counters, port-B write control and registered output values
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bl_d          = bl_q;
        tgt_d         = tgt_q;
        tgt_ok_d      = tgt_ok_q;
        hit_valid_d   = 1'b0;
        hit_type_d    = '0;
        hit_kill_d    = 1'b0;
        level_clear_d = 1'b0;
        we_b          = 1'b0;
        wa_b          = cnt_q;
        wd_b          = ld_data;

        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    bl_d    = '0;
                end
            end
            S_LOAD: begin
                if (ld_valid && ld_ready_q) begin
                    we_b = 1'b1;
                    wa_b = cnt_q;
                    wd_b = ld_data;
                    if (is_breakable(ld_data)) begin
                        bl_d = bl_q + 11'd1;
                    end
                    if (cnt_q == LAST) begin
                        state_d       = S_RUN;
                        level_clear_d = (bl_d == '0);
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            S_RUN: begin
                if (load_start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    bl_d    = '0;
                end else if (destroy && d_ready_q) begin
                    state_d  = S_HIT_RD;
                    tgt_d    = cell_addr(d_row, d_col);
                    tgt_ok_d = in_field(d_row, d_col);
                end
            end
            S_HIT_RD: begin
                if (load_start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    bl_d    = '0;
                end else begin
                    state_d = S_HIT_WR;
                end
            end
            S_HIT_WR: begin
                if (load_start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    bl_d    = '0;
                end else begin
                    state_d = S_RUN;
                    if (tgt_ok_q && is_breakable(rd_b_q)) begin
                        we_b        = 1'b1;
                        wa_b        = tgt_q;
                        wd_b        = new_type;
                        hit_valid_d = 1'b1;
                        hit_type_d  = rd_b_q;
                        hit_kill_d  = (new_type == '0);
                        if ((new_type == '0) && (bl_q != '0)) begin
                            bl_d          = bl_q - 11'd1;
                            level_clear_d = (bl_q == 11'd1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        a_ok_d     = (state_q != S_IDLE) && in_field(row, col);
        d_ready_d  = (state_d == S_RUN);
        ld_ready_d = (state_d == S_LOAD);
        busy_d     = (state_d == S_LOAD);
    end

    // Control FSM and all registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bl_q          <= '0;
            tgt_q         <= '0;
            tgt_ok_q      <= 1'b0;
            a_ok_q        <= 1'b0;
            hit_valid_q   <= 1'b0;
            hit_type_q    <= '0;
            hit_kill_q    <= 1'b0;
            level_clear_q <= 1'b0;
            d_ready_q     <= 1'b0;
            ld_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bl_q          <= bl_d;
            tgt_q         <= tgt_d;
            tgt_ok_q      <= tgt_ok_d;
            a_ok_q        <= a_ok_d;
            hit_valid_q   <= hit_valid_d;
            hit_type_q    <= hit_type_d;
            hit_kill_q    <= hit_kill_d;
            level_clear_q <= level_clear_d;
            d_ready_q     <= d_ready_d;
            ld_ready_q    <= ld_ready_d;
            busy_q        <= busy_d;
        end
    end

    // Dual-port map RAM: port A scans, port B loads and read-modify-writes; reads return old data
    always_ff @(posedge clock) begin
        if (we_b) begin
            mem[wa_b] <= wd_b;
        end
        rd_a_q <= mem[a_addr];
        rd_b_q <= mem[tgt_q];
    end

    assign block       = a_ok_q ? rd_a_q : '0;
    assign d_ready     = d_ready_q;
    assign ld_ready    = ld_ready_q;
    assign blocks_left = bl_q;
    assign hit_valid   = hit_valid_q;
    assign hit_type    = hit_type_q;
    assign hit_kill    = hit_kill_q;
    assign level_clear = level_clear_q;
    assign busy        = busy_q;

endmodule
